// File: rtl/message_rx_queue.sv
// message_rx_queue: MESSAGE2PACKET-stage receive queue.
// Builds messages (start + body chunks) from the bus slave into packets
// (generated head flit + body flits), queues complete packets in a ring of
// slots, and offers the head slot to the output port via request/grant.

`ifndef FLIT_WIDTH
`define FLIT_WIDTH 32
`endif
`ifndef BUS_DATA_WIDTH
`define BUS_DATA_WIDTH 32
`endif
`ifndef BUS_ADDRESS_WIDTH
`define BUS_ADDRESS_WIDTH 16
`endif
`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 8
`endif
`ifndef FLIT_TYPE_BITS
`define FLIT_TYPE_BITS 31:30
`endif
`ifndef CMD_BITS_HEAD_FLIT
`define CMD_BITS_HEAD_FLIT 29
`endif
`ifndef HEAD_FLIT_ADDRESS_BITS
`define HEAD_FLIT_ADDRESS_BITS 15:0
`endif
`ifndef HEAD_FLIT
`define HEAD_FLIT 2'b01
`endif
`ifndef HEAD_TAIL_FLIT
`define HEAD_TAIL_FLIT 2'b11
`endif

module message_rx_queue #(
   parameter int QUEUE_DEPTH    = 8,
   parameter int N_BITS_POINTER = 3,
   parameter int N_BITS_CHUNK   = 3
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        start_i,
   input  logic [`BUS_ADDRESS_WIDTH-1:0]               address_i,
   input  logic                                        transaction_type_i,
   input  logic                                        chunk_i,
   input  logic [`BUS_DATA_WIDTH-1:0]                  data_i,
   input  logic                                        last_i,
   input  logic                                        abort_i,
   output logic                                        ready_o,
   output logic                                        overflow_o,
   output logic [`MAX_PACKET_LENGHT*`FLIT_WIDTH-1:0]   out_link_o,
   output logic [`MAX_PACKET_LENGHT-1:0]               out_sel_o,
   output logic                                        r_msg_to_pkt_o,
   input  logic                                        g_msg_to_pkt_i
);

   localparam int FW = `FLIT_WIDTH;
   localparam int ML = `MAX_PACKET_LENGHT;
   localparam logic [N_BITS_POINTER-1:0] PTR_LAST  = N_BITS_POINTER'(QUEUE_DEPTH-1);
   localparam logic [N_BITS_CHUNK-1:0]   CHUNK_MAX = N_BITS_CHUNK'(ML-1);

   typedef enum logic {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

   // Packet slot storage; data is not reset, validity alone qualifies it.
   logic [QUEUE_DEPTH-1:0][ML-1:0][FW-1:0] r_flits;
   logic [QUEUE_DEPTH-1:0][ML-1:0]         r_sel;
   logic [QUEUE_DEPTH-1:0]                 r_valid;
   logic [N_BITS_POINTER-1:0]              r_head;
   logic [N_BITS_POINTER-1:0]              r_tail;
   logic [N_BITS_CHUNK-1:0]                r_cnt;
   logic                                   r_overflow;
   state_t                                 r_state;
   state_t                                 w_state_nxt;

   logic                       w_accept;
   logic                       w_chunk_evt;
   logic                       w_chunk_store;
   logic                       w_chunk_drop;
   logic                       w_commit;
   logic                       w_grant;
   logic                       w_abort;
   logic [N_BITS_CHUNK-1:0]    w_idx;
   logic [FW-1:0]              w_head_flit;
   logic [N_BITS_POINTER-1:0]  w_tail_nxt;
   logic [N_BITS_POINTER-1:0]  w_head_nxt;

   // FSM state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // FSM next state: writes collect body chunks, reads commit immediately
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start_i && ready_o && transaction_type_i) w_state_nxt = S_COLLECT;
         end
         S_COLLECT: begin
            if (abort_i)              w_state_nxt = S_IDLE;
            else if (chunk_i && last_i) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // FSM outputs: a new message is accepted only in IDLE with a free tail slot
   always_comb begin
      ready_o = 1'b0;
      if (r_state == S_IDLE) ready_o = !r_valid[r_tail];
   end

   // Datapath control decode
   always_comb begin
      w_accept      = start_i && ready_o;
      w_abort       = (r_state == S_COLLECT) && abort_i;
      w_chunk_evt   = (r_state == S_COLLECT) && !abort_i && chunk_i;
      w_chunk_store = w_chunk_evt && (r_cnt != CHUNK_MAX);
      w_chunk_drop  = w_chunk_evt && (r_cnt == CHUNK_MAX);
      w_commit      = (w_accept && !transaction_type_i) || (w_chunk_evt && last_i);
      w_grant       = g_msg_to_pkt_i && r_valid[r_head];
      w_idx         = r_cnt + 1'b1;
      w_tail_nxt    = (r_tail == PTR_LAST) ? '0 : r_tail + 1'b1;
      w_head_nxt    = (r_head == PTR_LAST) ? '0 : r_head + 1'b1;
   end

   // Head flit: only address, command and flit type fields are populated
   always_comb begin
      w_head_flit                          = '0;
      w_head_flit[`HEAD_FLIT_ADDRESS_BITS] = address_i;
      w_head_flit[`CMD_BITS_HEAD_FLIT]     = transaction_type_i;
      w_head_flit[`FLIT_TYPE_BITS]         = transaction_type_i ? `HEAD_FLIT : `HEAD_TAIL_FLIT;
   end

   // Queue control: valid bits, pointers, chunk counter, overflow pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_cnt      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_chunk_drop;
         // commit and grant never touch the same slot, so both may apply
         if (w_commit) begin
            r_valid[r_tail] <= 1'b1;
            r_tail          <= w_tail_nxt;
         end
         if (w_grant) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= w_head_nxt;
         end
         if (w_accept || w_abort || w_commit) r_cnt <= '0;
         else if (w_chunk_store)              r_cnt <= r_cnt + 1'b1;
      end
   end

   // Slot contents: head flit on accept, body flits while collecting
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_flits[r_tail][0] <= w_head_flit;
         r_sel[r_tail]      <= ML'(1);
      end else if (w_chunk_store) begin
         r_flits[r_tail][w_idx] <= data_i;
         r_sel[r_tail][w_idx]   <= 1'b1;
      end
   end

   // Output side is a pure view of the head slot
   always_comb begin
      r_msg_to_pkt_o = r_valid[r_head];
      out_sel_o      = r_valid[r_head] ? r_sel[r_head] : '0;
      out_link_o     = r_flits[r_head];
      overflow_o     = r_overflow;
   end

endmodule
